// File: rtl/frame_datagram_sync.sv
// frame_datagram_sync: holds a game-core datagram and commits it to the
// quadrant outputs only on a synchronised vblank rising edge.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_datagram offer;
// vblank level; overrun_clr; datagram_out, commit_pulse, frame_count, overrun.
// MESSAGE_SIZE defaults to the constants.svh datagram width (12 bits).
// Macro OVERWRITE_PENDING_EN: a new offer may replace a pending datagram.
module frame_datagram_sync #(
   parameter int MESSAGE_SIZE = 12,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [MESSAGE_SIZE-1:0] in_datagram,
   input  logic                    vblank,
   input  logic                    overrun_clr,
   output logic [MESSAGE_SIZE-1:0] datagram_out,
   output logic                    commit_pulse,
   output logic [7:0]              frame_count,
   output logic                    overrun
);

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      COMMIT
   } state_t;

   state_t                  state;
   logic [MESSAGE_SIZE-1:0] staging;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic [SYNC_STAGES-1:0]  fill_q;
   logic                    synced;
   logic                    settled;
   logic                    vb_prev;
   logic                    armed;
   logic                    vb_rise;
   logic                    xfer;

   assign synced  = sync_q[SYNC_STAGES-1];
   assign settled = fill_q[SYNC_STAGES-1];

`ifdef OVERWRITE_PENDING_EN
   assign in_ready = !rst && (state == IDLE || state == PENDING);
`else
   assign in_ready = !rst && (state == IDLE);
`endif

   assign xfer = in_valid && in_ready;

   // fill_q marks when the chain holds real samples rather than reset
   // zeros; a rise is only armed once a real low has been seen, so a
   // vblank already high at reset release is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         fill_q  <= '0;
         vb_prev <= 1'b0;
         armed   <= 1'b0;
         vb_rise <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], vblank};
         fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         vb_prev <= synced;
         armed   <= armed | (settled & ~synced);
         vb_rise <= settled & armed & synced & ~vb_prev;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         staging      <= '0;
         datagram_out <= '0;
         commit_pulse <= 1'b0;
         frame_count  <= 8'd0;
      end else begin
         commit_pulse <= 1'b0;
         if (vb_rise)
            frame_count <= frame_count + 8'd1;
         unique case (state)
            IDLE: begin
               // a rise coinciding with acceptance belongs to this frame,
               // so the datagram waits for the next one
               if (xfer) begin
                  staging <= in_datagram;
                  state   <= PENDING;
               end
            end
            PENDING: begin
`ifdef OVERWRITE_PENDING_EN
               if (xfer)
                  staging <= in_datagram;
               if (vb_rise) begin
                  datagram_out <= xfer ? in_datagram : staging;
                  commit_pulse <= 1'b1;
                  state        <= COMMIT;
               end
`else
               if (vb_rise) begin
                  datagram_out <= staging;
                  commit_pulse <= 1'b1;
                  state        <= COMMIT;
               end
`endif
            end
            COMMIT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef OVERWRITE_PENDING_EN
   // set has priority over clear
   always_ff @(posedge clk) begin
      if (rst)
         overrun <= 1'b0;
      else if (state == PENDING && xfer)
         overrun <= 1'b1;
      else if (overrun_clr)
         overrun <= 1'b0;
   end
`else
   logic unused_overrun_clr;
   assign unused_overrun_clr = overrun_clr;
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_frame_datagram_sync.sv
// Testbench for frame_datagram_sync: directed offers and vblank edges,
// commits checked by a scoreboard monitor against queued expectations.
module tb_frame_datagram_sync;

   localparam int MS = 12;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [MS-1:0] in_datagram;
   logic          vblank;
   logic          overrun_clr;
   logic [MS-1:0] datagram_out;
   logic          commit_pulse;
   logic [7:0]    frame_count;
   logic          overrun;

   frame_datagram_sync #(
      .MESSAGE_SIZE(MS),
      .SYNC_STAGES (SS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_datagram (in_datagram),
      .vblank      (vblank),
      .overrun_clr (overrun_clr),
      .datagram_out(datagram_out),
      .commit_pulse(commit_pulse),
      .frame_count (frame_count),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [MS-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          q[$];
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   int            exp_fc   = 0;
   logic [MS-1:0] exp_out;
   logic [MS-1:0] last_out;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic offer(input logic [MS-1:0] d);
      in_valid    = 1'b1;
      in_datagram = d;
      chk("offer_ready", {31'd0, in_ready}, 1);
      tick(1);
      in_valid = 1'b0;
   endtask

   // raise vblank, expect the commit SS+2 edges later, then drop it
   task automatic rise_commit(input logic [MS-1:0] d);
      exp_t e;
      e.data = d;
      e.cyc  = cyc + SS + 2;
      vblank = 1'b1;
      q.push_back(e);
      exp_fc = (exp_fc + 1) % 256;
      tick(SS + 4);
      vblank = 1'b0;
      tick(4);
   endtask

   task automatic pulse();
      vblank = 1'b1;
      tick(3);
      vblank = 1'b0;
      tick(3);
      exp_fc = (exp_fc + 1) % 256;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && commit_pulse) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit: got commit at cycle %0d data %0h expected none",
                     cyc, datagram_out);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("commit_data", {20'd0, datagram_out}, {20'd0, e.data});
            chk("commit_cycle", cyc, e.cyc);
         end
      end
      if (!rst && !commit_pulse && datagram_out !== last_out) begin
         checks++;
         failures++;
         $display("FAIL out_stable: got %0h expected %0h", datagram_out, last_out);
      end
      last_out = datagram_out;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_datagram = '0;
      vblank      = 1'b0;
      overrun_clr = 1'b0;
      tick(3);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      rst = 1'b0;
      tick(1);
      chk("rst_out", {20'd0, datagram_out}, 0);
      chk("rst_fc", {24'd0, frame_count}, 0);
      chk("rst_overrun", {31'd0, overrun}, 0);
      chk("rst_commit", {31'd0, commit_pulse}, 0);
      chk("idle_ready", {31'd0, in_ready}, 1);
      tick(5);

      // basic commit with latency
      offer(12'h5A5);
      rise_commit(12'h5A5);
      chk("basic_out", {20'd0, datagram_out}, 32'h5A5);
      chk("basic_fc", {24'd0, frame_count}, exp_fc);

      // transfer coincident with vb_rise in IDLE
      vblank = 1'b1;
      tick(SS + 1);
      in_valid    = 1'b1;
      in_datagram = 12'h3C3;
      tick(1);
      in_valid = 1'b0;
      exp_fc   = (exp_fc + 1) % 256;
      tick(3);
      vblank = 1'b0;
      tick(4);
      chk("coinc_no_commit", {20'd0, datagram_out}, 32'h5A5);
      chk("coinc_fc1", {24'd0, frame_count}, exp_fc);
      rise_commit(12'h3C3);
      chk("coinc_out", {20'd0, datagram_out}, 32'h3C3);
      chk("coinc_fc2", {24'd0, frame_count}, 3);

`ifdef OVERWRITE_PENDING_EN
      offer(12'h0AA);
      offer(12'h0BB);
      chk("ovw_overrun", {31'd0, overrun}, 1);
      rise_commit(12'h0BB);
      chk("ovw_out", {20'd0, datagram_out}, 32'h0BB);
      chk("ovw_overrun_held", {31'd0, overrun}, 1);
      overrun_clr = 1'b1;
      tick(1);
      overrun_clr = 1'b0;
      chk("ovw_clr", {31'd0, overrun}, 0);
      exp_out = 12'h0BB;
`else
      offer(12'h246);
      in_valid    = 1'b1;
      in_datagram = 12'h111;
      chk("stall_ready", {31'd0, in_ready}, 0);
      begin
         exp_t e;
         e.data = 12'h246;
         e.cyc  = cyc + SS + 2;
         q.push_back(e);
      end
      vblank = 1'b1;
      exp_fc = (exp_fc + 1) % 256;
      k = 0;
      while (!in_ready && k < 20) begin
         tick(1);
         k++;
      end
      chk("stall_timeout", {31'd0, k < 20}, 1);
      chk("stall_held_out", {20'd0, datagram_out}, 32'h246);
      tick(1);
      in_valid = 1'b0;
      vblank   = 1'b0;
      tick(4);
      rise_commit(12'h111);
      chk("stall_second_out", {20'd0, datagram_out}, 32'h111);
      exp_out = 12'h111;
`endif
      chk("fc_before_wrap", {24'd0, frame_count}, exp_fc);

      // wrap with nothing pending
      while (exp_fc != 255) pulse();
      chk("fc_255", {24'd0, frame_count}, 255);
      pulse();
      chk("fc_wrap", {24'd0, frame_count}, 0);
      chk("wrap_out_held", {20'd0, datagram_out}, {20'd0, exp_out});

      // reset while pending with vblank held high
      offer(12'h777);
      vblank = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(2);
      chk("rst2_in_ready", {31'd0, in_ready}, 0);
      rst = 1'b0;
      tick(1);
      exp_fc = 0;
      chk("rst2_out", {20'd0, datagram_out}, 0);
      chk("rst2_fc", {24'd0, frame_count}, 0);
      chk("rst2_overrun", {31'd0, overrun}, 0);
      tick(10);
      chk("held_no_rise", {24'd0, frame_count}, 0);
      offer(12'h123);
      vblank = 1'b0;
      tick(4);
      rise_commit(12'h123);
      chk("post_rst_fc", {24'd0, frame_count}, 1);
      chk("post_rst_out", {20'd0, datagram_out}, 32'h123);

      tick(2);
      chk("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
